// File: rtl/iq_deserializer.sv
// Serial-to-parallel I/Q frame receiver: finds the frame alignment, verifies it, tracks lock and counts sync errors.
// Optional build macro IQDESER_CTRL_STRIP_EN: drop the word control bit (LSB) and sign-extend the 13-bit sample.
`timescale 1ns/1ps
module iq_deserializer #(
   parameter int unsigned LOCK_FRAMES = 4,
   parameter int unsigned MISS_LIMIT  = 3,
   parameter int unsigned ERRCNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bit_en,
   input  logic                serial_in,
   output logic [13:0]         i_out,
   output logic [13:0]         q_out,
   output logic                iq_valid,
   output logic                locked,
   output logic [ERRCNT_W-1:0] sync_err_cnt
);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
   localparam logic [3:0] MISS_N = 4'(MISS_LIMIT);

   state_t      state;
   logic [31:0] shreg;
   logic [31:0] shreg_nxt;
   logic [4:0]  bit_cnt;
   logic [3:0]  good_cnt;
   logic [3:0]  miss_cnt;
   logic        good;
   logic [13:0] i_word;
   logic [13:0] q_word;
   logic [13:0] i_dec;
   logic [13:0] q_dec;

   // Frame checks look at the contents including the bit accepted this cycle
   always_comb begin
      shreg_nxt = {shreg[30:0], serial_in};
      good      = (shreg_nxt[31:30] == 2'b10) && (shreg_nxt[15:14] == 2'b01);
      i_word    = shreg_nxt[29:16];
      q_word    = shreg_nxt[13:0];
`ifdef IQDESER_CTRL_STRIP_EN
      i_dec     = {i_word[13], i_word[13:1]};
      q_dec     = {q_word[13], q_word[13:1]};
`else
      i_dec     = i_word;
      q_dec     = q_word;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= HUNT;
         shreg        <= '0;
         bit_cnt      <= '0;
         good_cnt     <= '0;
         miss_cnt     <= '0;
         i_out        <= '0;
         q_out        <= '0;
         iq_valid     <= 1'b0;
         locked       <= 1'b0;
         sync_err_cnt <= '0;
      end else begin
         iq_valid <= 1'b0;
         if (bit_en) begin
            shreg   <= shreg_nxt;
            // 5-bit counter wraps on its own; 31 marks the 32nd bit since the last check
            bit_cnt <= bit_cnt + 5'd1;
            case (state)
               HUNT: begin
                  if (good) begin
                     bit_cnt  <= '0;
                     good_cnt <= 4'd1;
                     if (LOCK_N == 4'd1) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        miss_cnt <= '0;
                     end else begin
                        state <= VERIFY;
                     end
                  end
               end
               VERIFY: begin
                  if (bit_cnt == 5'd31) begin
                     if (good) begin
                        good_cnt <= good_cnt + 4'd1;
                        if ((good_cnt + 4'd1) == LOCK_N) begin
                           state    <= LOCKED;
                           locked   <= 1'b1;
                           miss_cnt <= '0;
                        end
                     end else begin
                        state    <= HUNT;
                        good_cnt <= '0;
                     end
                  end
               end
               LOCKED: begin
                  if (bit_cnt == 5'd31) begin
                     if (good) begin
                        i_out    <= i_dec;
                        q_out    <= q_dec;
                        iq_valid <= 1'b1;
                        miss_cnt <= '0;
                     end else begin
                        if (sync_err_cnt != '1)
                           sync_err_cnt <= sync_err_cnt + 1'b1;
                        if ((miss_cnt + 4'd1) == MISS_N) begin
                           state    <= HUNT;
                           locked   <= 1'b0;
                           good_cnt <= '0;
                           miss_cnt <= '0;
                        end else begin
                           miss_cnt <= miss_cnt + 4'd1;
                        end
                     end
                  end
               end
               default: begin
                  state  <= HUNT;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iq_deserializer.sv
// Scoreboard bench for iq_deserializer: main instance with default parameters plus a narrow-counter instance.
`timescale 1ns/1ps
module tb_iq_deserializer;

   logic        clk;
   logic        rst;
   logic        rst_s;
   logic        bit_en;
   logic        serial_in;
   logic [13:0] i_out, q_out;
   logic        iq_valid, locked;
   logic [15:0] sync_err_cnt;
   logic [13:0] i_out_s, q_out_s;
   logic        iq_valid_s, locked_s;
   logic [3:0]  sync_err_cnt_s;

   iq_deserializer #(.LOCK_FRAMES(4), .MISS_LIMIT(3), .ERRCNT_W(16)) dut (
      .clk(clk), .rst(rst), .bit_en(bit_en), .serial_in(serial_in),
      .i_out(i_out), .q_out(q_out), .iq_valid(iq_valid), .locked(locked),
      .sync_err_cnt(sync_err_cnt)
   );

   iq_deserializer #(.LOCK_FRAMES(4), .MISS_LIMIT(15), .ERRCNT_W(4)) dut_sat (
      .clk(clk), .rst(rst_s), .bit_en(bit_en), .serial_in(serial_in),
      .i_out(i_out_s), .q_out(q_out_s), .iq_valid(iq_valid_s), .locked(locked_s),
      .sync_err_cnt(sync_err_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int unsigned act;
      int unsigned exp;
   } chk_t;

   chk_t        chk_q[$];
   logic [27:0] exp_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cyc = 0;
   int unsigned last_v = 0;
   int unsigned exp_gap = 0;
   int unsigned stride = 1;
   logic        prev_v = 1'b0;
   chk_t        c;
   logic [27:0] e;

   function automatic logic [13:0] dec(input logic [13:0] w);
`ifdef IQDESER_CTRL_STRIP_EN
      return {w[13], w[13:1]};
`else
      return w;
`endif
   endfunction

   task automatic chk(input string n, input int unsigned a, input int unsigned x);
      chk_q.push_back('{n, a, x});
   endtask

   task automatic send_bit(input logic b);
      bit_en = 1'b1;
      serial_in = b;
      @(posedge clk);
      #1;
      bit_en = 1'b0;
      serial_in = 1'b0;
      repeat (stride - 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [13:0] i, input logic [13:0] q,
                             input logic [1:0] isync, input bit push);
      logic [31:0] w;
      w = {isync, i, 2'b01, q};
      if (push) exp_q.push_back({dec(i), dec(q)});
      for (int b = 31; b >= 0; b--) send_bit(w[b]);
   endtask

   task automatic send_frames(input int unsigned n, input logic [13:0] i, input logic [13:0] q,
                              input logic [1:0] isync);
      for (int unsigned k = 0; k < n; k++) send_frame(i, q, isync, 1'b0);
   endtask

   task automatic reset_main();
      rst = 1'b1;
      bit_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Single owner of the pass/fail counters: compares queued checks and every iq_valid pulse
   always @(negedge clk) begin
      cyc++;
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         n_cmp++;
         if (c.act != c.exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
         end
      end
      if (iq_valid) begin
         n_cmp++;
         if (prev_v) begin
            n_bad++;
            $display("FAIL iq_valid_width: got 2+ cycles expected 1 at cycle %0d", cyc);
         end
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_iq_valid: got i=%0h q=%0h expected no pulse", i_out, q_out);
         end else begin
            e = exp_q.pop_front();
            if ({i_out, q_out} != e) begin
               n_bad++;
               $display("FAIL iq_word: got i=%0h q=%0h expected i=%0h q=%0h",
                        i_out, q_out, e[27:14], e[13:0]);
            end
         end
         if (exp_gap != 0) begin
            n_cmp++;
            if ((cyc - last_v) != exp_gap) begin
               n_bad++;
               $display("FAIL iq_valid_gap: got %0d expected %0d", cyc - last_v, exp_gap);
            end
         end
         last_v = cyc;
      end
      prev_v = iq_valid;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no end of stimulus expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] w;
      logic [13:0] strip_i;
      rst = 1'b1;
      rst_s = 1'b1;
      bit_en = 1'b0;
      serial_in = 1'b0;

      // Reset values, then lock on a clean stream from reset
      reset_main();
      chk("rst_i_out", 32'(i_out), 0);
      chk("rst_q_out", 32'(q_out), 0);
      chk("rst_iq_valid", 32'(iq_valid), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_err", 32'(sync_err_cnt), 0);
      send_frames(3, 14'h1ABC, 14'h0123, 2'b10);
      chk("lock_after3", 32'(locked), 0);
      send_frames(1, 14'h1ABC, 14'h0123, 2'b10);
      chk("lock_after4", 32'(locked), 1);
      send_frame(14'h1ABC, 14'h0123, 2'b10, 1'b1);

      // Stream starting 7 bits into a frame
      reset_main();
      w = {2'b10, 14'h0003, 2'b01, 14'h0007};
      for (int b = 24; b >= 0; b--) send_bit(w[b]);
      send_frames(3, 14'h0003, 14'h0007, 2'b10);
      chk("misalign_lock3", 32'(locked), 0);
      send_frames(1, 14'h0003, 14'h0007, 2'b10);
      chk("misalign_lock4", 32'(locked), 1);
      send_frame(14'h0003, 14'h0007, 2'b10, 1'b1);

      // Sync errors while locked, loss of lock, relock keeps the error count
      reset_main();
      send_frames(4, 14'h0003, 14'h0007, 2'b10);
      send_frame(14'h0003, 14'h0007, 2'b10, 1'b1);
      send_frames(2, 14'h0003, 14'h0007, 2'b11);
      chk("err_after2", 32'(sync_err_cnt), 2);
      chk("locked_after2bad", 32'(locked), 1);
      send_frame(14'h0003, 14'h0007, 2'b10, 1'b1);
      send_frames(2, 14'h0003, 14'h0007, 2'b11);
      chk("locked_after2more", 32'(locked), 1);
      send_frames(1, 14'h0003, 14'h0007, 2'b11);
      chk("locked_after3bad", 32'(locked), 0);
      chk("err_after5", 32'(sync_err_cnt), 5);
      send_frames(3, 14'h0003, 14'h0007, 2'b10);
      chk("relock_3", 32'(locked), 0);
      send_frames(1, 14'h0003, 14'h0007, 2'b10);
      chk("relock_4", 32'(locked), 1);
      chk("err_kept", 32'(sync_err_cnt), 5);
      send_frame(14'h0003, 14'h0007, 2'b10, 1'b1);

      // Sparse bit_en: one bit every 4 cycles gives one pulse per 128 cycles
      reset_main();
      stride = 4;
      send_frames(4, 14'h0003, 14'h0007, 2'b10);
      chk("sparse_lock", 32'(locked), 1);
      send_frame(14'h0003, 14'h0007, 2'b10, 1'b1);
      exp_gap = 128;
      send_frame(14'h0003, 14'h0007, 2'b10, 1'b1);
      send_frame(14'h1ABC, 14'h0123, 2'b10, 1'b1);
      exp_gap = 0;
      stride = 1;

      // Control-bit handling
`ifdef IQDESER_CTRL_STRIP_EN
      strip_i = 14'h3000;
`else
      strip_i = 14'h2001;
`endif
      exp_q.push_back({strip_i, dec(14'h0002)});
      send_frame(14'h2001, 14'h0002, 2'b10, 1'b0);

      // Reset in the middle of a frame while locked
      w = {2'b10, 14'h0003, 2'b01, 14'h0007};
      for (int b = 31; b >= 22; b--) send_bit(w[b]);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_i_out", 32'(i_out), 0);
      chk("midrst_q_out", 32'(q_out), 0);
      chk("midrst_locked", 32'(locked), 0);
      chk("midrst_err", 32'(sync_err_cnt), 0);
      chk("midrst_valid", 32'(iq_valid), 0);
      rst = 1'b0;
      send_frames(3, 14'h0003, 14'h0007, 2'b10);
      chk("midrst_relock3", 32'(locked), 0);
      send_frames(1, 14'h0003, 14'h0007, 2'b10);
      chk("midrst_relock4", 32'(locked), 1);

      // Bad frame during VERIFY restarts the good-frame count
      reset_main();
      send_frames(2, 14'h0003, 14'h0007, 2'b10);
      send_frames(1, 14'h0003, 14'h0007, 2'b11);
      chk("verify_bad", 32'(locked), 0);
      send_frames(3, 14'h0003, 14'h0007, 2'b10);
      chk("verify_fresh3", 32'(locked), 0);
      send_frames(1, 14'h0003, 14'h0007, 2'b10);
      chk("verify_fresh4", 32'(locked), 1);

      // Narrow error counter saturation (main instance parked in reset)
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_s = 1'b0;
      send_frames(4, 14'h0003, 14'h0007, 2'b10);
      chk("sat_lock", 32'(locked_s), 1);
      send_frames(14, 14'h0003, 14'h0007, 2'b11);
      chk("sat_locked14", 32'(locked_s), 1);
      chk("sat_err14", 32'(sync_err_cnt_s), 14);
      send_frames(1, 14'h0003, 14'h0007, 2'b11);
      chk("sat_unlock15", 32'(locked_s), 0);
      chk("sat_err15", 32'(sync_err_cnt_s), 15);
      send_frames(4, 14'h0003, 14'h0007, 2'b10);
      chk("sat_relock", 32'(locked_s), 1);
      send_frames(5, 14'h0003, 14'h0007, 2'b11);
      chk("sat_err20", 32'(sync_err_cnt_s), 15);
      chk("sat_locked20", 32'(locked_s), 1);

      repeat (3) @(posedge clk);
      chk("pending_expect", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/iq_deserializer.md
Name: iq_deserializer

Overview:
- Receive-path counterpart of the transmit IQ serializer. Sits directly downstream of the radio LVDS capture stage (rxclk/rxd09 domain, already retimed to clk).
- Recovers 32-bit I/Q frames from the serial bit stream, aligns on the I/Q sync patterns and presents parallel 14-bit I and Q words with a one-cycle valid strobe.
- Feeds the future FSK demodulator.
- Frame format is the same one the serializer emits, MSB first:
  - bits[31:30] = I_SYNC 2'b10
  - bits[29:16] = I word
  - bits[15:14] = Q_SYNC 2'b01
  - bits[13:0] = Q word

Parameters:
- LOCK_FRAMES, 4: consecutive good frames needed in VERIFY to declare lock (1..15).
- MISS_LIMIT, 3: consecutive bad frames in LOCKED before returning to HUNT (1..15).
- ERRCNT_W, 16: width of the saturating sync-error counter.

Ports:
- clk, input, 1: system clock. Single clock domain.
- rst, input, 1: synchronous, active-high reset.
- bit_en, input, 1: serial_in holds a new bit this cycle.
- serial_in, input, 1: recovered serial I/Q bit, MSB first.
- i_out, output, 14: I word of the last good frame.
- q_out, output, 14: Q word of the last good frame.
- iq_valid, output, 1: one-cycle strobe; i_out/q_out updated this cycle.
- locked, output, 1: high while the state machine is in LOCKED.
- sync_err_cnt, output, ERRCNT_W: saturating count of bad frames seen while LOCKED.

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high.
- Reset values: i_out=0, q_out=0, iq_valid=0, locked=0, sync_err_cnt=0, state=HUNT. Internal state also clears: shift register, bit counter, good/miss counters.
- Shift register:
  - 32-bit, shifts left, new bit enters at the LSB, only on cycles with bit_en=1.
  - With bit_en=0 nothing advances and iq_valid=0.
- Frame check: a frame is "good" when shreg[31:30]==2'b10 and shreg[15:14]==2'b01, evaluated on the updated shift-register contents.
- HUNT:
  - Check every accepted bit.
  - On a good frame: go to VERIFY, bit_cnt=0, good_cnt=1.
- VERIFY:
  - bit_cnt counts accepted bits 0..31 and wraps.
  - Check only at the frame boundary (the 32nd bit after the last check).
  - Good frame: good_cnt+1. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - Bad frame: go to HUNT immediately; that bit is not re-checked for alignment until the next accepted bit.
- LOCKED:
  - Check at each frame boundary.
  - Good frame: latch i_out=shreg[29:16] and q_out=shreg[13:0], pulse iq_valid for exactly one cycle, miss_cnt=0.
  - Bad frame: no iq_valid, i_out/q_out hold, sync_err_cnt+1 (saturates at all-ones, never wraps), miss_cnt+1.
  - When miss_cnt reaches MISS_LIMIT: go to HUNT, locked falls on that same edge, good_cnt=0.
- Output timing:
  - locked is registered. It rises on the edge that enters LOCKED.
  - The first iq_valid comes at the next frame boundary, not on the lock edge.
- Latency: iq_valid asserts on the clk edge that accepts the 32nd bit (Q LSB) of a good frame.
- sync_err_cnt keeps its value across loss of lock. Only rst clears it.
- Reset mid-frame: all partial state is discarded and the block re-hunts from an empty shift register. A good frame cannot be found until 32 bits have been accepted after reset.
- Sticky bits: bit_en held low for any number of cycles does not affect state or counters.

Optional Feature:
- Macro: IQDESER_CTRL_STRIP_EN.
- Defined:
  - The control bit (word LSB) is dropped. i_out = {I[13], I[13:1]}, and q_out likewise, i.e. the 13-bit sample sign-extended to 14 bits.
  - Control bits are ignored entirely.
- Undefined: i_out/q_out carry the raw 14-bit words including the control bit.
- Port widths are identical in both builds.

Test Plan:
- Reset → all outputs 0; no frame is checked until 32 bits are accepted. Then feed 4 frames I=14'h1ABC, Q=14'h0123 with bit_en every cycle → locked rises after the 4th frame boundary. Frame 5 → iq_valid pulses once, i_out=14'h1ABC, q_out=14'h0123.
- Start the stream 7 bits into a frame (misaligned) → block locks on the true boundary. No iq_valid before lock. i_out never shows a shifted value.
- Locked, corrupt I_SYNC to 2'b11 in 2 consecutive frames then a good frame → sync_err_cnt=2, locked stays 1, iq_valid resumes. Then 3 consecutive bad frames → locked=0 on the 3rd boundary, sync_err_cnt=5.
- Bad frame during VERIFY (frame 3) → returns to HUNT. Needs 4 fresh good frames to lock.
- bit_en=1 only every 4th cycle → identical decoded words; iq_valid is one cycle wide at 1/128 cycle rate.
- Force ERRCNT_W=4, apply 20 bad frames with MISS_LIMIT=15 and re-lock between them → sync_err_cnt saturates at 4'hF.
- With IQDESER_CTRL_STRIP_EN: I=14'h2001 → i_out=14'h3000. Without the macro: i_out=14'h2001.
- Assert rst mid-frame while locked → next cycle all outputs 0 and state HUNT.
